// File: rtl/countdown_timer_bcd.sv
// BCD countdown timer with prescaled tick, load/start/pause control and a one-cycle done pulse.
// Optional warn output is enabled by defining TIMER_WARN_EN.
module countdown_timer_bcd #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned WARN_SECS = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                start_i,
  input  logic                pause_i,
  input  logic [4*DIGITS-1:0] preset_i,
  output logic [4*DIGITS-1:0] remain_o,
  output logic                running_o,
  output logic                expired_o,
  output logic                done_pulse_o
`ifdef TIMER_WARN_EN
  ,
  output logic                warn_o
`endif
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned W   = 4 * DIGITS;
  localparam logic [PW-1:0] PreMax = PW'(DIV - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  if (DIV < 2 || DIGITS < 1 || DIGITS > 4 || WARN_SECS > 9) begin : g_param_err
    $error("countdown_timer_bcd: illegal parameter combination");
  end

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  remain_q, remain_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_q, done_d;
  logic [W-1:0]  dec;

  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] s;
    for (int i = 0; i < int'(DIGITS); i++) begin
      s[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return s;
  endfunction

  // Ripple borrow from the least significant digit; a 0 digit under borrow becomes 9.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] s;
    logic         borrow;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          s[4*i +: 4] = 4'd9;
        end else begin
          s[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        s[4*i +: 4] = v[4*i +: 4];
      end
    end
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    pre_d    = pre_q;
    dec      = bcd_dec(remain_q);
    if (load_i) begin
      remain_d = sanitize(preset_i);
      pre_d    = '0;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (remain_q != '0) begin
              state_d = StRun;
              pre_d   = '0;
            end else begin
              state_d = StDone;
            end
          end
        end
        StRun: begin
          // Pause wins over a coincident tick; prescaler is held for resume.
          if (pause_i) begin
            state_d = StPause;
          end else if (pre_q == PreMax) begin
            pre_d    = '0;
            remain_d = dec;
            if (dec == '0) state_d = StDone;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        StPause: begin
          if (start_i) state_d = StRun;
        end
        default: begin
          remain_d = '0;
        end
      endcase
    end
    done_d = (state_d == StDone) && (state_q != StDone);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      remain_q <= '0;
      pre_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      pre_q    <= pre_d;
      done_q   <= done_d;
    end
  end

  assign remain_o     = remain_q;
  assign running_o    = (state_q == StRun);
  assign expired_o    = (state_q == StDone);
  assign done_pulse_o = done_q;

`ifdef TIMER_WARN_EN
  logic hi_zero;
  always_comb begin
    hi_zero = 1'b1;
    for (int i = 1; i < int'(DIGITS); i++) begin
      if (remain_q[4*i +: 4] != 4'd0) hi_zero = 1'b0;
    end
    warn_o = ((state_q == StRun) || (state_q == StPause)) && hi_zero &&
             (remain_q[3:0] <= 4'(WARN_SECS));
  end
`endif

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench: an integer-valued reference model predicts each cycle's outputs for a
// 2-digit and a 3-digit instance sharing the same controls.
module tb_countdown_timer_bcd;

  localparam int DIV = 4;
  localparam int SIdle = 0, SRun = 1, SPause = 2, SDone = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, start, pause;
  logic [7:0]  preset2;
  logic [11:0] preset3;
  logic [7:0]  remain2;
  logic [11:0] remain3;
  logic        run2, exp2, dp2, run3, exp3, dp3;
`ifdef TIMER_WARN_EN
  logic        warn2, warn3;
`endif

  countdown_timer_bcd #(.CLK_HZ(4), .TICK_HZ(1), .DIGITS(2), .WARN_SECS(5)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .start_i(start), .pause_i(pause),
    .preset_i(preset2), .remain_o(remain2), .running_o(run2), .expired_o(exp2),
    .done_pulse_o(dp2)
`ifdef TIMER_WARN_EN
    , .warn_o(warn2)
`endif
  );

  countdown_timer_bcd #(.CLK_HZ(4), .TICK_HZ(1), .DIGITS(3), .WARN_SECS(5)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .start_i(start), .pause_i(pause),
    .preset_i(preset3), .remain_o(remain3), .running_o(run3), .expired_o(exp3),
    .done_pulse_o(dp3)
`ifdef TIMER_WARN_EN
    , .warn_o(warn3)
`endif
  );

  typedef struct {int st; int pre; int rem; bit dp;} mdl_t;
  typedef struct {
    logic [7:0] rem2; logic run2; logic exp2; logic dp2; logic wrn2;
    logic [11:0] rem3; logic run3; logic exp3; logic dp3;
  } exp_t;

  exp_t sb_q[$];
  mdl_t m2 = '{0, 0, 0, 1'b0};
  mdl_t m3 = '{0, 0, 0, 1'b0};
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic int san(input logic [15:0] bcd, input int nd);
    int v = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      logic [3:0] d;
      d = bcd[4*i +: 4];
      if (d > 4'd9) d = 4'd9;
      v = v * 10 + int'(d);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic mdl_t nxt(input mdl_t m, input bit r, input bit ld, input bit st,
                               input bit ps, input int pv);
    mdl_t n;
    n = m;
    n.dp = 1'b0;
    if (r) begin
      n.st = SIdle; n.pre = 0; n.rem = 0;
      return n;
    end
    if (ld) begin
      n.st = SIdle; n.pre = 0; n.rem = pv;
      return n;
    end
    case (m.st)
      SIdle: if (st) begin
        if (m.rem != 0) begin n.st = SRun; n.pre = 0; end
        else n.st = SDone;
      end
      SRun: begin
        if (ps) n.st = SPause;
        else if (m.pre == DIV - 1) begin
          n.pre = 0;
          n.rem = m.rem - 1;
          if (n.rem == 0) n.st = SDone;
        end else n.pre = m.pre + 1;
      end
      SPause: if (st) n.st = SRun;
      default: ;
    endcase
    n.dp = (n.st == SDone) && (m.st != SDone);
    return n;
  endfunction

  task automatic cyc(input bit r, input bit ld, input bit st, input bit ps);
    exp_t e, o;
    logic [15:0] b;
    rst = r; load = ld; start = st; pause = ps;
    m2 = nxt(m2, r, ld, st, ps, san({8'h00, preset2}, 2));
    m3 = nxt(m3, r, ld, st, ps, san({4'h0, preset3}, 3));
    b = to_bcd(m2.rem);
    e.rem2 = b[7:0];
    e.run2 = (m2.st == SRun);
    e.exp2 = (m2.st == SDone);
    e.dp2  = m2.dp;
    e.wrn2 = ((m2.st == SRun) || (m2.st == SPause)) && (m2.rem <= 5);
    b = to_bcd(m3.rem);
    e.rem3 = b[11:0];
    e.run3 = (m3.st == SRun);
    e.exp3 = (m3.st == SDone);
    e.dp3  = m3.dp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check("remain2", 32'(remain2), 32'(o.rem2));
    check("running2", 32'(run2), 32'(o.run2));
    check("expired2", 32'(exp2), 32'(o.exp2));
    check("done_pulse2", 32'(dp2), 32'(o.dp2));
`ifdef TIMER_WARN_EN
    check("warn2", 32'(warn2), 32'(o.wrn2));
`endif
    check("remain3", 32'(remain3), 32'(o.rem3));
    check("running3", 32'(run3), 32'(o.run3));
    check("expired3", 32'(exp3), 32'(o.exp3));
    check("done_pulse3", 32'(dp3), 32'(o.dp3));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_start(input logic [7:0] p2, input logic [11:0] p3);
    preset2 = p2; preset3 = p3;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    preset2 = 8'h00; preset3 = 12'h000;
    #2;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Full countdown from 12 with expiry hold and start/pause ignored in DONE
    load_start(8'h12, 12'h012);
    idle(48);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Pause at remain 10 / prescaler 2, hold, resume; then pause on the tick cycle
    preset2 = 8'h12; preset3 = 12'h012;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(20);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Borrow across digits
    load_start(8'h10, 12'h100);
    idle(6);

    // Clamp of non-BCD digits, then zero preset going straight to DONE
    preset2 = 8'h3C; preset3 = 12'hF3C;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    load_start(8'h00, 12'h000);
    idle(2);

    // Reset mid-run at 07, then load mid-run (also with start held)
    load_start(8'h08, 12'h008);
    idle(5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    load_start(8'h15, 12'h015);
    idle(3);
    preset2 = 8'h42; preset3 = 12'h042;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Warning window: counts down from 7 with a pause in the warn range
    load_start(8'h07, 12'h007);
    idle(12);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
